instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 25 ++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// =============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared core definitions: fetch states, reset PC and NOP encoding.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0013;  // addi x0,x0,0

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// =============================================================================
// Module   : instr_fetch
// Brief    : Single-outstanding instruction fetch with redirect and back-pressure.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic [31:0]  pc_plus4_d;
  logic [31:0]  redirect_tgt_d;

  assign pc_plus4_d     = pc_q + 32'd4;
  assign redirect_tgt_d = word_align(redirect_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (redirect_en && imem_ack) begin
            // Response arrives with the redirect: drop it and refetch at once.
            pc_q <= redirect_tgt_d;
          end else if (redirect_en) begin
            pc_q    <= redirect_tgt_d;
            state_q <= ST_DRAIN;
          end else if (imem_ack) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
            pc_q       <= pc_plus4_d;
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect_en) begin
            instr_q <= NOP_INSTR;
            pc_q    <= redirect_tgt_d;
            state_q <= ST_FETCH;
          end else if (instr_ready) begin
            state_q <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (redirect_en) begin
            pc_q <= redirect_tgt_d;
          end
          if (imem_ack) begin
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign imem_req    = !rst && (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = !rst && (state_q == ST_HOLD);
  assign instruction = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// =============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch with a random-latency memory model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int unsigned lat_min = 2;
  int unsigned lat_max = 2;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds the first-fetch word, the rest a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_valid(input int max_cyc, output int cyc);
    cyc = 0;
    while (!instr_valid && cyc < max_cyc) begin
      step();
      cyc++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: no instr_valid within %0d cycles", max_cyc);
    end
  endtask

  // Memory: one request at a time, random latency, spurious acks while HOLDing.
  logic        m_busy = 1'b0;
  logic [31:0] m_addr;
  int unsigned m_wait;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  end

  always @(negedge clk) begin
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (rst) begin
      m_busy = 1'b0;
    end else begin
      if (!m_busy && imem_req) begin
        m_busy = 1'b1;
        m_addr = imem_addr;
        m_wait = $urandom_range(lat_max, lat_min);
      end
      if (m_busy) begin
        if (m_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(m_addr);
          m_busy     = 1'b0;
        end else begin
          m_wait--;
        end
      end else if (instr_valid && ($urandom_range(3, 0) == 0)) begin
        imem_ack = 1'b1;
      end
    end
  end

  // Reference model + scoreboard: the program stream is sequential words from
  // the last reset/redirect target; only accepted instructions leave it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc = RST_PC;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: instr_valid with empty expectation queue");
      end else begin
        e = exp_q[0];
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_instruction", instruction, e.word);
        if (instr_ready && !redirect_en) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    if (rst) begin
      exp_q.delete();
      next_pc = RST_PC;
    end else if (redirect_en) begin
      exp_q.delete();
      next_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: next_pc, word: mem_word(next_pc)});
      next_pc += 32'd4;
    end
  end

  initial begin
    int          cyc;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;

    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_instr_pc", instr_pc, RST_PC);

    // First fetch with two-cycle memory latency.
    rst = 1'b0;
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, RST_PC);
    wait_for_valid(20, cyc);
    chk("first_latency", 32'(cyc), 32'd3);
    chk("first_instr", instruction, 32'h0000_0093);
    chk("first_pc", instr_pc, 32'h0);

    // Back-pressure.
    hold_instr = instruction;
    hold_pc    = instr_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'h0, instr_valid}, 32'h1);
      chk("bp_instr", instruction, hold_instr);
      chk("bp_pc", instr_pc, hold_pc);
      chk("bp_req", {31'h0, imem_req}, 32'h0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("next_req", {31'h0, imem_req}, 32'h1);
    chk("next_addr", imem_addr, 32'h4);

    // Redirect before the ack: stale response must be drained.
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_en = 1'b0;
    chk("drain_req", {31'h0, imem_req}, 32'h0);
    chk("drain_valid", {31'h0, instr_valid}, 32'h0);
    cyc = 0;
    while (!imem_req && cyc < 20) begin
      chk("drain_no_valid", {31'h0, instr_valid}, 32'h0);
      step();
      cyc++;
    end
    chk("redir_req", {31'h0, imem_req}, 32'h1);
    chk("redir_addr", imem_addr, 32'h0000_0100);

    instr_ready = 1'b1;
    wait_for_valid(20, cyc);
    lat_min = 0;
    lat_max = 0;
    step();
    instr_ready = 1'b0;

    // Redirect in the same cycle as the ack (zero-latency memory).
    chk("sim_pre_addr", imem_addr, 32'h0000_0104);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect_en = 1'b0;
    chk("sim_req", {31'h0, imem_req}, 32'h1);
    chk("sim_addr", imem_addr, 32'h0000_0040);
    chk("sim_valid", {31'h0, instr_valid}, 32'h0);

    // Redirect beats ready in HOLD.
    wait_for_valid(20, cyc);
    chk("hr_pc_before", instr_pc, 32'h0000_0040);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0080;
    instr_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    instr_ready = 1'b0;
    chk("hr_instr", instruction, NOP);
    chk("hr_valid", {31'h0, instr_valid}, 32'h0);
    chk("hr_req", {31'h0, imem_req}, 32'h1);
    chk("hr_addr", imem_addr, 32'h0000_0080);

    // Wrap-around at the top of the address space.
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_for_valid(20, cyc);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    lat_min     = 3;
    lat_max     = 3;
    step();
    instr_ready = 1'b0;
    chk("wrap_req", {31'h0, imem_req}, 32'h1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset while a request is outstanding.
    rst = 1'b1;
    step();
    chk("mr_req", {31'h0, imem_req}, 32'h0);
    chk("mr_valid", {31'h0, instr_valid}, 32'h0);
    chk("mr_instr", instruction, NOP);
    chk("mr_pc", instr_pc, RST_PC);
    rst = 1'b0;
    #1;
    chk("mr_restart_req", {31'h0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr, RST_PC);

    // Random traffic against the scoreboard.
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 2000; i++) begin
      step();
      instr_ready = ($urandom_range(9, 0) < 7);
      redirect_en = ($urandom_range(15, 0) == 0);
      redirect_pc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                : $urandom;
      rst         = ($urandom_range(199, 0) == 0);
    end
    rst         = 1'b0;
    redirect_en = 1'b0;
    instr_ready = 1'b1;
    repeat (20) step();
    chk("progress", 32'(pops > 50), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
